// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle result strobes.
// Optional 8E1 even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_byte_receiver #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = 16
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       frame_error_out,
   output logic       parity_error_out,
   output logic       busy_out
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_nxt;
   logic [7:0]       shreg, sh_nxt;
   logic [7:0]       data_nxt;
   logic             valid_nxt, ferr_nxt;
   logic             rx_meta, rx_s;

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_nxt, perr_nxt, perr_q;
`endif

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         bit_idx         <= '0;
         shreg           <= '0;
         data_out        <= '0;
         valid_out       <= 1'b0;
         frame_error_out <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad         <= 1'b0;
         perr_q          <= 1'b0;
`endif
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         bit_idx         <= bit_nxt;
         shreg           <= sh_nxt;
         data_out        <= data_nxt;
         valid_out       <= valid_nxt;
         frame_error_out <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
         par_bad         <= par_nxt;
         perr_q          <= perr_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      bit_nxt   = bit_idx;
      sh_nxt    = shreg;
      data_nxt  = data_out;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt   = par_bad;
      perr_nxt  = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // Half a bit in: a line that is high again was only a glitch.
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               sh_nxt  = {rx_s, shreg[7:1]};
               bit_nxt = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx == 3'd7) state_nxt = PARITY;
`else
               if (bit_idx == 3'd7) state_nxt = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               par_nxt   = ^{shreg, rx_s};
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) begin
                     perr_nxt = 1'b1;
                  end else begin
                     data_nxt  = shreg;
                     valid_nxt = 1'b1;
                  end
`else
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
`endif
               end else begin
                  // Bad stop wins over any parity result; wait out a break.
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef UART_RX_PARITY_EN
   assign parity_error_out = perr_q;
`else
   assign parity_error_out = 1'b0;
`endif

   assign busy_out = (state != IDLE);

endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
- Serial-to-parallel byte receiver in front of memory_programmer. Loads program bytes over a 1-wire UART line from the host.
- Deserialises 8N1 frames on rx_in. Presents each received byte on data_out with a one-cycle valid_out strobe.
- data_out drives memory_programmer data_in; valid_out tells the programmer a new byte is ready to write.

Parameters:
- CLKS_PER_BIT, 434, clock_in cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
- CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clock_in  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idle high.
- data_out  output  8  last correctly received byte; held until the next good frame.
- valid_out  output  1  one-cycle pulse when data_out has just been updated.
- frame_error_out  output  1  one-cycle pulse when a stop bit is sampled low.
- parity_error_out  output  1  one-cycle pulse on parity mismatch (see Optional Feature).
- busy_out  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data_out=8'h00, valid_out=0, frame_error_out=0, parity_error_out=0, busy_out=0. FSM=IDLE, counters=0, synchroniser flops=1.
- A reset asserted mid-frame aborts the frame immediately; no strobe is produced for it.
- Input sync: rx_in passes through 2 flops (rx_s). All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s==0 -> START, counter cleared.
- START:
  - Count to (CLKS_PER_BIT/2)-1 (integer divide).
  - At that count, rx_s==0 -> DATA with counter and bit index cleared.
  - At that count, rx_s==1 -> IDLE as a glitch; no strobe.
- DATA:
  - Counter runs 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, shift rx_s into a shift register LSB-first (bit 0 first).
  - After the 8th sample -> STOP (or PARITY state when the optional feature is enabled).
- STOP:
  - Sample at CLKS_PER_BIT-1.
  - rx_s==1: data_out <= shift register; valid_out=1 for exactly the next cycle; -> IDLE.
  - rx_s==0: frame_error_out=1 for one cycle; data_out unchanged; -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s==1, then -> IDLE. A break condition (line held low) therefore yields one error pulse, not repeated frames.
- Latency: valid_out rises 1 clock after the stop-bit sample edge. That is ~9.5 bit times + 2 sync cycles + 1 after the start edge.
- Back-to-back frames: a new start bit immediately after the stop sample (without a full stop-bit duration) is accepted. IDLE re-arms on the cycle after STOP.
- Strobe exclusivity: valid_out, frame_error_out and parity_error_out are mutually exclusive in any cycle.
- Counter wrap: the counter never exceeds CLKS_PER_BIT-1; it resets to 0 on every state transition.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP, sampled at CLKS_PER_BIT-1.
  - Even parity: XOR of 8 data bits and parity bit must be 0.
  - Mismatch: the frame still proceeds to STOP. If the stop bit is good, parity_error_out pulses for one cycle in place of valid_out, and data_out is not updated.
  - A bad stop bit takes priority: frame_error_out only.
- Undefined: no PARITY state; parity_error_out tied 0.

Test Plan:
- All tests use CLKS_PER_BIT=4.
- Reset then idle line: hold rx_in=1 for 100 cycles -> all outputs stay 0, busy_out=0.
- Single frame 8'hA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop=1) -> data_out=8'hA5, exactly one valid_out pulse, busy_out low afterwards.
- Back-to-back 8'h11, 8'hAA, 8'hFF with no idle gap -> three valid_out pulses carrying 11, AA, FF in order; no errors.
- Glitch: rx_in low for 1 bit-quarter (1 cycle post-sync) then high -> FSM returns to IDLE; no strobe; data_out unchanged.
- Frame 8'h3C with stop bit 0, line then held low 40 cycles before going high -> one frame_error_out pulse; data_out retains previous value. A following frame 8'h55 is received correctly.
- Reset asserted during DATA of frame 8'hF0 -> outputs return to reset values that cycle; no valid_out. With UART_RX_PARITY_EN defined, frame 8'h01 with parity 0 -> parity_error_out pulse, no valid_out.
